// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq_core.
// master: drives in_valid/op/a/b/cin and out_ready, sees in_ready and the registered result/flags.
// slave:  the core side; mirror of master.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             cout;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, result_hi, cout, zero, neg, ovf
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, result_hi, cout, zero, neg, ovf
    );
endinterface

// File: rtl/alu_seq_core.sv
// Sequential ALU: AND/ADD/SUB/OR/XOR in one cycle, optional shift-add MUL (macro ALU_SEQ_MUL_EN).
// Latency: 1 cycle after accept for logic/arith ops, WIDTH+1 cycles for MUL; all outputs registered.
// Backpressure: single request in flight; result held in DONE until out_ready, in_ready only in IDLE.
// Ports: clk, rst (async active-high), bus (alu_seq_if.slave: in handshake, op/a/b/cin, out handshake, result/flags).
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0101;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam int         CNT_W  = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    // Single-cycle ALU evaluated straight from the request; it is only sampled on the accept edge.
    logic [WIDTH:0]   add_ext, sub_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout, alu_ovf;

    always_comb begin
        add_ext  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
        // Extra bit of the W+1-bit difference is the borrow out.
        sub_ext  = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cin};
        alu_res  = bus.a & bus.b;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res  = add_ext[WIDTH-1:0];
                alu_cout = add_ext[WIDTH];
                alu_ovf  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res  = sub_ext[WIDTH-1:0];
                alu_cout = sub_ext[WIDTH];
                alu_ovf  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            default: alu_res = bus.a & bus.b;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // Shift-add multiplier: acc holds {partial_hi, remaining multiplier bits}; each step conditionally
    // adds the multiplicand into the high half then shifts the whole thing right by one.
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     step_sum;

    always_comb begin
        step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    end
`endif

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (bus.op == OP_MUL) begin
                        state_d = EXEC;
                        mcand_d = bus.a;
                        acc_d   = {{WIDTH{1'b0}}, bus.b};
                        cnt_d   = '0;
                    end else begin
`else
                    begin
`endif
                        state_d     = DONE;
                        result_d    = alu_res;
                        result_hi_d = '0;
                        cout_d      = alu_cout;
                        zero_d      = (alu_res == '0);
                        neg_d       = alu_res[WIDTH-1];
                        ovf_d       = alu_ovf;
                    end
                end
            end
`ifdef ALU_SEQ_MUL_EN
            EXEC: begin
                // WIDTH step cycles, then one cycle to publish the product and flags.
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d     = DONE;
                    result_d    = acc_q[WIDTH-1:0];
                    result_hi_d = acc_q[2*WIDTH-1:WIDTH];
                    cout_d      = 1'b0;
                    zero_d      = (acc_q == '0);
                    neg_d       = acc_q[2*WIDTH-1];
                    ovf_d       = (acc_q[2*WIDTH-1:WIDTH] != '0);
                end else begin
                    acc_d = {step_sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_alu_seq_core.sv
module tb_alu_seq_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   seen;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq_core #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // flags packed as {cout, zero, neg, ovf}
    task automatic check_out(input string tag, input logic [7:0] res, input logic [7:0] hi,
                             input logic [3:0] flags);
        check({tag, ".result"}, 64'(bus.result), 64'(res));
        check({tag, ".result_hi"}, 64'(bus.result_hi), 64'(hi));
        check({tag, ".flags"}, 64'({bus.cout, bus.zero, bus.neg, bus.ovf}), 64'(flags));
    endtask

    // Present one request, scramble the inputs right after the accept edge, and measure cycles
    // until out_valid (sampled on negedges); gives up after 40 cycles.
    task automatic do_req(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, output int n);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = op; bus.a = a; bus.b = b; bus.cin = cin;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = 4'b0010; bus.a = ~a; bus.b = ~b; bus.cin = ~cin;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus.out_valid) break;
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check({tag, ".in_ready_hs"}, 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".out_valid_after"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check({tag, ".in_ready_after"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.op = 4'h0; bus.a = 8'h00; bus.b = 8'h00;
        bus.cin = 1'b0; bus.out_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check_out("rst", 8'h00, 8'h00, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        check("rst.in_ready", 64'(bus.in_ready), 64'd1);

        // ADD FF+01: wraps to zero with carry
        do_req(4'b0001, 8'hFF, 8'h01, 1'b0, lat);
        check("add1.lat", 64'(lat), 64'd1);
        check_out("add1", 8'h00, 8'h00, 4'b1100);
        // hold off the consumer for 5 cycles: everything frozen
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.out_valid", 64'(bus.out_valid), 64'd1);
            check("bp.in_ready", 64'(bus.in_ready), 64'd0);
            check_out("bp", 8'h00, 8'h00, 4'b1100);
        end
        release_out("add1");

        // ADD 7F+00+cin: signed overflow into negative
        do_req(4'b0001, 8'h7F, 8'h00, 1'b1, lat);
        check("add2.lat", 64'(lat), 64'd1);
        check_out("add2", 8'h80, 8'h00, 4'b0011);
        release_out("add2");

        // SUB 80-01: signed overflow, no borrow
        do_req(4'b0010, 8'h80, 8'h01, 1'b0, lat);
        check("sub1.lat", 64'(lat), 64'd1);
        check_out("sub1", 8'h7F, 8'h00, 4'b0001);
        release_out("sub1");

        // SUB 00-00-borrow_in: borrow out, -1
        do_req(4'b0010, 8'h00, 8'h00, 1'b1, lat);
        check_out("sub2", 8'hFF, 8'h00, 4'b1010);
        release_out("sub2");

        // XOR AA^55
        do_req(4'b0101, 8'hAA, 8'h55, 1'b1, lat);
        check("xor.lat", 64'(lat), 64'd1);
        check_out("xor", 8'hFF, 8'h00, 4'b0010);
        release_out("xor");

        // OR 30|03
        do_req(4'b0011, 8'h30, 8'h03, 1'b0, lat);
        check_out("or", 8'h33, 8'h00, 4'b0000);
        release_out("or");

        // AND and an undefined opcode both act as AND
        do_req(4'b0000, 8'h0F, 8'hF0, 1'b0, lat);
        check_out("and", 8'h00, 8'h00, 4'b0100);
        release_out("and");
        do_req(4'b1111, 8'hF0, 8'h3C, 1'b1, lat);
        check_out("op_f", 8'h30, 8'h00, 4'b0000);
        release_out("op_f");

`ifdef ALU_SEQ_MUL_EN
        // MUL FF*FF = FE01
        do_req(4'b0100, 8'hFF, 8'hFF, 1'b0, lat);
        check("mul1.lat", 64'(lat), 64'd9);
        check_out("mul1", 8'h01, 8'hFE, 4'b0011);
        release_out("mul1");

        // MUL 0F*11 = 00FF
        do_req(4'b0100, 8'h0F, 8'h11, 1'b0, lat);
        check("mul2.lat", 64'(lat), 64'd9);
        check_out("mul2", 8'hFF, 8'h00, 4'b0000);
        release_out("mul2");

        // reset in the middle of a MUL
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 4'b0100; bus.a = 8'hFF; bus.b = 8'hFF;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("abort.out_valid_pre", 64'(bus.out_valid), 64'd0);
        rst = 1'b1;
        #1;
`else
        // opcode 0100 without the multiplier behaves as AND
        do_req(4'b0100, 8'hF0, 8'h3C, 1'b0, lat);
        check("mul_off.lat", 64'(lat), 64'd1);
        check_out("mul_off", 8'h30, 8'h00, 4'b0000);
        // reset while a result is pending in DONE
        @(negedge clk);
        rst = 1'b1;
        #1;
`endif
        check("abort.out_valid", 64'(bus.out_valid), 64'd0);
        check_out("abort", 8'h00, 8'h00, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort.in_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort.no_result", 64'(seen), 64'd0);

        do_req(4'b0001, 8'h02, 8'h03, 1'b0, lat);
        check("post.lat", 64'(lat), 64'd1);
        check_out("post", 8'h05, 8'h00, 4'b0000);
        release_out("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
